// File: rtl/dual_xor_sig_pkg.sv
// Shared constants and LFSR helpers for the dual-XOR signature design.
// Masks and seeds are held at 32 bits; users slice them down to M.
package dual_xor_sig_pkg;

  localparam logic [31:0] PT_SEED = 32'h0000_0001;
  localparam logic [31:0] KA_SEED = 32'h0000_ACE1;
  localparam logic [31:0] KB_SEED = 32'hFFFF_FFFF;

  function automatic logic [31:0] lfsr_mask(input int m);
    logic [31:0] mask;
    case (m)
      8:       mask = 32'h0000_00B8;
      16:      mask = 32'h0000_B400;
      24:      mask = 32'h00E1_0000;
      default: mask = 32'h8020_0003;
    endcase
    return mask;
  endfunction

  // Right-shift Galois step; the state must be zero-extended to 32 bits
  function automatic logic [31:0] lfsr_next(input logic [31:0] state, input logic [31:0] mask);
    return state[0] ? ((state >> 1) ^ mask) : (state >> 1);
  endfunction

endpackage

// File: rtl/xor_lfsr_stage.sv
// One keystream LFSR: advances on en, exposes its state and its key bit (state[0]).
module xor_lfsr_stage
  import dual_xor_sig_pkg::*;
#(
  parameter int           M    = 32,
  parameter logic [M-1:0] SEED = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [M-1:0] state,
  output logic         key_bit
);

  localparam logic [31:0] MASK32 = lfsr_mask(M);

  logic [M-1:0] state_q, state_d;
  logic [31:0]  next_full;

  always_comb begin
    next_full = lfsr_next(32'(state_q), MASK32);
    state_d   = state_q;
    if (en) state_d = next_full[M-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SEED;
    else     state_q <= state_d;
  end

  assign state   = state_q;
  assign key_bit = state_q[0];

endmodule

// File: rtl/dual_xor_fpga_signature.sv
// Self-checking dual-XOR cipher top: PT LFSR, encrypt/decrypt pipeline, MISR, snapshot counter.
// Optional serial frame output on tx is built when DXS_SERIAL_TX_EN is defined.
module dual_xor_fpga_signature
  import dual_xor_sig_pkg::*;
#(
  parameter int M              = 32,
  parameter int tx_cntr_period = 2000
) (
  input  logic         clk,
  input  logic         rst,
  output logic         tx,
  output logic         sig_valid,
  output logic [M-1:0] signature,
  output logic         error
);

  localparam logic [31:0]   MASK32   = lfsr_mask(M);
  localparam logic [M-1:0]  MASK     = MASK32[M-1:0];
  localparam int            CW       = $clog2(tx_cntr_period);
  localparam logic [CW-1:0] CNT_LAST = CW'(tx_cntr_period - 1);

  logic [M-1:0]  pt_q, pt_d, sig_q, sig_d, signature_q, signature_d;
  logic [31:0]   pt_full;
  logic          c_q, c_d, d_q, d_d, v1_q, v1_d, v2_q, v2_d;
  logic          p1_q, p1_d, p2_q, p2_d;
  logic          error_q, error_d, sig_valid_q, sig_valid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;
  logic          ka_bit, kb_bit, kad_bit, kbd_bit;
  logic [M-1:0]  unused_ka_state, unused_kb_state, unused_kad_state, unused_kbd_state;

  xor_lfsr_stage #(.M(M), .SEED(KA_SEED[M-1:0])) u_ka_enc (
    .clk(clk), .rst(rst), .en(1'b1), .state(unused_ka_state), .key_bit(ka_bit));
  xor_lfsr_stage #(.M(M), .SEED(KB_SEED[M-1:0])) u_kb_enc (
    .clk(clk), .rst(rst), .en(1'b1), .state(unused_kb_state), .key_bit(kb_bit));
  // Decrypt keys step only alongside valid ciphertext so they stay one step behind the encrypt pair
  xor_lfsr_stage #(.M(M), .SEED(KA_SEED[M-1:0])) u_ka_dec (
    .clk(clk), .rst(rst), .en(v1_q), .state(unused_kad_state), .key_bit(kad_bit));
  xor_lfsr_stage #(.M(M), .SEED(KB_SEED[M-1:0])) u_kb_dec (
    .clk(clk), .rst(rst), .en(v1_q), .state(unused_kbd_state), .key_bit(kbd_bit));

  assign wrap = (cnt_q == CNT_LAST);

  always_comb begin
    pt_full     = lfsr_next(32'(pt_q), MASK32);
    pt_d        = pt_full[M-1:0];
    c_d         = pt_q[0] ^ ka_bit ^ kb_bit;
    v1_d        = 1'b1;
    d_d         = d_q;
    if (v1_q) d_d = c_q ^ kad_bit ^ kbd_bit;
    v2_d        = v1_q;
    p1_d        = pt_q[0];
    p2_d        = p1_q;
    sig_d       = sig_q;
    if (v2_q) sig_d = (sig_q >> 1) ^ ((sig_q[0] ^ d_q) ? MASK : '0);
    error_d     = error_q | (v2_q & (d_q != p2_q));
    cnt_d       = wrap ? '0 : cnt_q + CW'(1);
    signature_d = wrap ? sig_q : signature_q;
    sig_valid_d = wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pt_q        <= PT_SEED[M-1:0];
      c_q         <= 1'b0;
      d_q         <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      p1_q        <= 1'b0;
      p2_q        <= 1'b0;
      sig_q       <= '0;
      error_q     <= 1'b0;
      cnt_q       <= '0;
      signature_q <= '0;
      sig_valid_q <= 1'b0;
    end else begin
      pt_q        <= pt_d;
      c_q         <= c_d;
      d_q         <= d_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      sig_q       <= sig_d;
      error_q     <= error_d;
      cnt_q       <= cnt_d;
      signature_q <= signature_d;
      sig_valid_q <= sig_valid_d;
    end
  end

  assign signature = signature_q;
  assign sig_valid = sig_valid_q;
  assign error     = error_q;

`ifdef DXS_SERIAL_TX_EN
  localparam int BW = $clog2(M + 3);

  logic [M+1:0]  frame_q, frame_d;
  logic [BW-1:0] bits_q, bits_d;
  logic          tx_q, tx_d;

  // Frame is {stop, data, start} shifted out LSB first, one bit per clock
  always_comb begin
    frame_d = frame_q;
    bits_d  = bits_q;
    tx_d    = 1'b1;
    if (bits_q != '0) begin
      tx_d    = frame_q[0];
      frame_d = frame_q >> 1;
      bits_d  = bits_q - BW'(1);
    end
    if (wrap) begin
      frame_d = {1'b1, sig_q, 1'b0};
      bits_d  = BW'(M + 2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
      bits_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      frame_q <= frame_d;
      bits_q  <= bits_d;
      tx_q    <= tx_d;
    end
  end

  assign tx = tx_q;
`else
  assign tx = 1'b1;
`endif

endmodule

// File: tb/tb_dual_xor_fpga_signature.sv
// Bench for dual_xor_fpga_signature: plaintext/MISR model, per-cycle compare, reset and error scenarios.
module tb_dual_xor_fpga_signature;

  localparam int          M     = 32;
  localparam int          P     = 2000;
  localparam int          NSNAP = 5;
  localparam logic [31:0] MASK  = 32'h8020_0003;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tx, sig_valid, error;
  logic [M-1:0] signature;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int err_from = 0;
  bit cmp_en = 1'b0;

  logic [31:0] snap_exp [0:NSNAP];
  bit          pbits[$];

  dual_xor_fpga_signature #(.M(M), .tx_cntr_period(P)) dut (
    .clk(clk), .rst(rst), .tx(tx), .sig_valid(sig_valid),
    .signature(signature), .error(error));

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= rst ? 0 : edge_n + 1;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ MASK) : (s >> 1);
  endfunction

  function automatic logic [31:0] misr_absorb(input logic [31:0] s, input bit b);
    return (s[0] ^ b) ? ((s >> 1) ^ MASK) : (s >> 1);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s edge %0d: got %h expected %h", name, edge_n, act, exp);
    end
  endtask

  // Expected outputs from edge count since reset release
  always @(negedge clk) begin : cmp
    int k, off;
    logic [M-1:0] sig_e;
    logic sv_e, tx_e, err_e;
    if (cmp_en) begin
      k     = edge_n / P;
      off   = edge_n - k * P;
      sv_e  = 1'b0;
      sig_e = '0;
      tx_e  = 1'b1;
      err_e = 1'b0;
      if (!rst && k <= NSNAP) begin
        sv_e  = (k > 0 && off == 0);
        sig_e = (k == 0) ? '0 : snap_exp[k];
`ifdef DXS_SERIAL_TX_EN
        if (k > 0 && off == 1) tx_e = 1'b0;
        else if (k > 0 && off >= 2 && off <= M + 1) tx_e = sig_e[off-2];
`endif
        err_e = (err_from != 0 && edge_n >= err_from);
      end
      check("sig_valid", sig_valid, sv_e);
      check("signature", signature, sig_e);
      check("tx", tx, tx_e);
      check("error", error, err_e);
      $display("cycle edge=%0d rst=%0d sig_valid=%0d tx=%0d error=%0d signature=%h",
               edge_n, rst, sig_valid, tx, error, signature);
    end
  end

  initial begin
    logic [31:0] s, sg;
    logic        c_val;

    s = 32'h1;
    for (int n = 0; n < NSNAP * P + 4; n++) begin
      pbits.push_back(s[0]);
      s = lfsr_step(s);
    end
    check("model_pt_bits", {pbits[0], pbits[1], pbits[2], pbits[3]}, 64'b1101);
    sg = '0;
    for (int i = 0; i < 4; i++) sg = misr_absorb(sg, pbits[i]);
    check("model_misr4", sg, 64'h5014_0001);

    // Edge e absorbs the plaintext bit from edge e-3; edge k*P snapshots before absorbing
    sg = '0;
    snap_exp[0] = '0;
    for (int e = 1; e <= NSNAP * P; e++) begin
      if (e % P == 0) snap_exp[e / P] = sg;
      if (e >= 3) sg = misr_absorb(sg, pbits[e-3]);
    end

    cmp_en = 1'b1;
    rst = 1'b1;
    #100;
    rst = 1'b0;

    repeat (10010) @(posedge clk);
    #1;
    check("error_after_10k", error, 1'b0);
    rst = 1'b1;
    #1;
    check("tx_async_reset_midframe", tx, 1'b1);
    check("sig_valid_in_reset", sig_valid, 1'b0);
    check("signature_in_reset", signature, '0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    repeat (2040) @(posedge clk);
    #1;
    check("signature_rerun", signature, snap_exp[1]);

    c_val = dut.c_q;
    err_from = edge_n + 2;
    force dut.c_q = ~c_val;
    @(posedge clk);
    #1;
    release dut.c_q;
    check("error_before_compare", error, 1'b0);
    @(posedge clk);
    #1;
    check("error_rise", error, 1'b1);
    repeat (50) @(posedge clk);
    #1;
    check("error_sticky", error, 1'b1);

    cmp_en = 1'b0;
    rst = 1'b1;
    #1;
    check("error_cleared_by_rst", error, 1'b0);
    check("tx_in_final_reset", tx, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_xor_fpga_signature.md
# dual_xor_fpga_signature

Self-checking FPGA top for the dual-XOR stream cipher. An LFSR plaintext source is encrypted by XOR with two independent LFSR keystreams, then decrypted by an identical keystream pair. The decrypted bitstream feeds an M-bit signature register. Every `tx_cntr_period` cycles the signature is snapshotted and shifted out serially. A sticky error flag reports any plaintext/decrypt mismatch.

## Interface
- `M`, default 32, width of every LFSR and of the signature; legal values 8, 16, 24, 32.
- `tx_cntr_period`, default 2000, cycles between signature snapshots; must be ≥ M+2.
- `clk` input, 1 bit, the single clock; all state changes on the rising edge.
- `rst` input, 1 bit, asynchronous active-high reset.
- `tx` output, 1 bit, serial signature frame; idle high.
- `sig_valid` output, 1 bit, one-cycle pulse when a snapshot is taken.
- `signature` output, M bits, last snapshot taken.
- `error` output, 1 bit, sticky flag for a decrypt mismatch.

## Operation
- **LFSR step (all LFSRs):** right-shift Galois. If `s[0]`, next value is `(s>>1) ^ MASK`; otherwise next value is `s>>1`.
- **MASK per M:**
  - 8: 0xB8
  - 16: 0xB400
  - 24: 0xE10000
  - 32: 0x80200003
- **Seeds:** plaintext PT = 1; key A = 0xACE1 zero-extended to M; key B = all-ones.
- **Encrypt stage:** each cycle `c <= PT[0] ^ KA[0] ^ KB[0]`, and PT/KA/KB advance. `v1 <= 1`.
- **Decrypt stage:**
  - Holds its own KA'/KB' with the same seeds. They advance only when `v1` = 1.
  - When `v1`: `d <= c ^ KA'[0] ^ KB'[0]`. `v2 <= v1`.
- **Plaintext delay:** `PT[0]` is delayed two registers (`p2`) to align with `d`.
- **Signature MISR (`sig`, reset 0):**
  - Updates only when `v2`: `sig <= (sig>>1) ^ ((sig[0]^d) ? MASK : 0)`.
  - Holds otherwise.
- **Error:** set when `v2` and `d != p2`. Cleared only by `rst`.
- **Period counter:** counts 0 … `tx_cntr_period`-1, then wraps to 0.
  - On the wrap cycle: `signature <= sig`, `sig_valid` = 1, and the serialiser is loaded.
  - `sig` itself is not cleared.
- **Serialiser frame:** start bit 0, then `signature` LSB first (M bits), then stop bit 1. After the stop bit, `tx` idles at 1.
- **Reset values:**
  - `tx` = 1, `sig_valid` = 0, `signature` = 0, `error` = 0.
  - Counter = 0, `v1`/`v2` = 0, `c`/`d`/`p2` = 0.
  - All LFSRs at their seeds.
- **Reset mid-frame:** `tx` returns to 1 immediately (asynchronously). The frame is abandoned.

## Timing
- First edge after `rst` falls: `c` is valid (`v1` = 1).
- Second edge: `d` is valid (`v2` = 1).
- Third edge: first MISR absorb and first compare.
- Cipher latency from plaintext bit to decrypted bit: 2 cycles.
- First `sig_valid`: on the edge where the counter goes `tx_cntr_period`-1 → 0, i.e. edge number `tx_cntr_period` after reset release (2000 at defaults).
- Start bit appears on `tx` one cycle after `sig_valid`. Data bit i appears i+2 cycles after `sig_valid`. Stop bit appears M+2 cycles after `sig_valid`.
- One bit per clock; there is no baud divider.
- The frame always completes before the next snapshot, because `tx_cntr_period` ≥ M+2.

## Configuration
- Macro `DXS_SERIAL_TX_EN`.
- **Defined:** the serialiser is built and `tx` carries frames as described above.
- **Undefined:** the serialiser logic is omitted and `tx` is tied to 1. `signature`, `sig_valid` and `error` behave identically in both builds.

## Structure
- **Package `dual_xor_sig_pkg`:**
  - Function `lfsr_mask(M)` returning the masks listed above.
  - Seed constants `PT_SEED`, `KA_SEED`, `KB_SEED`.
  - Function `lfsr_next(state, mask)`.
- **Sub-module `xor_lfsr_stage`:**
  - Parameters: M and seed.
  - Ports: clk, rst, en, M-bit state out, key bit out.
  - Instantiated four times: encrypt KA/KB and decrypt KA'/KB'.
- **Wrapper contents:** PT LFSR, pipeline, MISR, counter and serialiser.

## Test plan
- Hold `rst` 100 ns, then release with a 10 ns clock → `tx` = 1, `sig_valid` = 0, `signature` = 0 and `error` = 0 during and after reset; `error` still 0 after 10000 cycles.
- Run 2000 cycles → a single-cycle `sig_valid` at edge 2000 after release; `signature` equals an independent MISR model of the plaintext delayed 2 cycles.
- With `DXS_SERIAL_TX_EN` defined → `tx` is 0 at `sig_valid`+1, `signature[i]` at +2+i, and 1 at +34; `tx` is 1 at all other times.
- Force `c` inverted for one cycle → `error` rises exactly 1 cycle later and stays 1 until `rst`.
- Assert `rst` at `sig_valid`+10 (mid-frame) → `tx` = 1 immediately. After release, the first `sig_valid` is again at edge 2000 with the same signature as the first run.
- Build without the macro → `tx` constantly 1 and `signature` identical to the previous scenarios.
